// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache between IF and Mem_ctrl
// Optional hit/miss counters enabled by defining ICACHE_STAT_EN.
module icache #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_MSB   = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instruction_read_flag,
    input  logic [31:0] instruction_read_address,
    output logic        instruction_flag,
    output logic [31:0] _instruction_read_address,
    output logic [31:0] instruction,
    output logic        mem_read_flag,
    output logic [31:0] mem_read_address,
    input  logic        mem_done,
    input  logic [31:0] mem_data
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_MSB - INDEX_BITS - 1;

    typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

    state_t                 state;
    logic [LINES-1:0]       valid;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [31:0]            data_mem [LINES];

    logic [INDEX_BITS-1:0]  req_index;
    logic [TAG_W-1:0]       req_tag;
    logic                   req_io;
    logic                   req_hit;
    logic [INDEX_BITS-1:0]  fill_index;
    logic [TAG_W-1:0]       fill_tag;
    logic                   fill_io;
    logic                   fill_en;
    logic                   fwd_match;

    always_comb begin
        req_index  = instruction_read_address[INDEX_BITS+1:2];
        req_tag    = instruction_read_address[ADDR_MSB:INDEX_BITS+2];
        req_io     = (instruction_read_address[ADDR_MSB -: 2] == 2'b11);
        req_hit    = valid[req_index] && (tag_mem[req_index] == req_tag) && !req_io;
        fill_index = mem_read_address[INDEX_BITS+1:2];
        fill_tag   = mem_read_address[ADDR_MSB:INDEX_BITS+2];
        fill_io    = (mem_read_address[ADDR_MSB -: 2] == 2'b11);
        fill_en    = (state == MISS) && mem_done && !fill_io;
        // Forward only if IF is still asking for the word being fetched.
        fwd_match  = instruction_read_flag && (instruction_read_address == mem_read_address);
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            valid                     <= '0;
            instruction_flag          <= 1'b0;
            _instruction_read_address <= 32'h0;
            instruction               <= 32'h0;
            mem_read_flag             <= 1'b0;
            mem_read_address          <= 32'h0;
        end else begin
            instruction_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (instruction_read_flag) begin
                        if (req_hit) begin
                            instruction_flag          <= 1'b1;
                            _instruction_read_address <= instruction_read_address;
                            instruction               <= data_mem[req_index];
                        end else begin
                            mem_read_flag    <= 1'b1;
                            mem_read_address <= instruction_read_address;
                            state            <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (mem_done) begin
                        if (!fill_io) begin
                            valid[fill_index] <= 1'b1;
                        end
                        mem_read_flag <= 1'b0;
                        state         <= RESP;
                        if (fwd_match) begin
                            instruction_flag          <= 1'b1;
                            _instruction_read_address <= mem_read_address;
                            instruction               <= mem_data;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else if (state == IDLE && instruction_read_flag) begin
            if (req_hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache against a line-map reference model
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        instruction_read_flag;
    logic [31:0] instruction_read_address;
    logic        instruction_flag;
    logic [31:0] resp_addr;
    logic [31:0] instruction;
    logic        mem_read_flag;
    logic [31:0] mem_read_address;
    logic        mem_done;
    logic [31:0] mem_data;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    icache dut (
        .clk                       (clk),
        .rst                       (rst),
        .instruction_read_flag     (instruction_read_flag),
        .instruction_read_address  (instruction_read_address),
        .instruction_flag          (instruction_flag),
        ._instruction_read_address (resp_addr),
        .instruction               (instruction),
        .mem_read_flag             (mem_read_flag),
        .mem_read_address          (mem_read_address),
        .mem_done                  (mem_done),
        .mem_data                  (mem_data)
`ifdef ICACHE_STAT_EN
        ,
        .hit_count                 (hit_count),
        .miss_count                (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Backing memory contents: a fixed scramble of the address, 0x13 at address 0.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    // Reference model: 128 one-word lines keyed by addr[8:2], tag addr[17:9].
    logic       model_valid [128];
    logic [8:0] model_tag   [128];
    int         exp_hits;
    int         exp_misses;

    function automatic bit is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'(a[8:2]);
        return !is_io(a) && model_valid[idx] && (model_tag[idx] == a[17:9]);
    endfunction

    function automatic void model_access(input logic [31:0] a);
        int idx;
        idx = int'(a[8:2]);
        if (model_hit(a)) begin
            exp_hits++;
        end else begin
            exp_misses++;
            if (!is_io(a)) begin
                model_valid[idx] = 1'b1;
                model_tag[idx]   = a[17:9];
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 128; i++) model_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    // Mem_ctrl stand-in: mem_done pulses after mem_lat cycles of mem_read_flag.
    int mem_lat = 4;
    bit responder_en = 1'b1;
    initial begin
        int cnt;
        cnt = 0;
        mem_done = 1'b0;
        mem_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (responder_en) begin
                mem_done = 1'b0;
                if (mem_read_flag) begin
                    cnt++;
                    if (cnt == mem_lat) begin
                        mem_done = 1'b1;
                        mem_data = word_of(mem_read_address);
                        cnt      = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Drives one request until a response (bounded), reporting what was seen.
    task automatic fetch(input logic [31:0] a, input int lat, output int cyc,
                         output int mrf, output logic [31:0] ra, output logic [31:0] ri);
        mem_lat = lat;
        instruction_read_flag = 1'b1;
        instruction_read_address = a;
        cyc = 0;
        mrf = 0;
        ra  = 32'h0;
        ri  = 32'h0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_read_flag) mrf++;
            if (instruction_flag) begin
                ra = resp_addr;
                ri = instruction;
                break;
            end
        end
        instruction_read_flag = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instruction_read_flag = 1'b0;
        instruction_read_address = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if ({instruction_flag, resp_addr, instruction, mem_read_flag, mem_read_address} !== 98'h0) begin
            errors++;
            $display("FAIL reset_outputs: got flag=%0b addr=%h instr=%h mrf=%0b maddr=%h, expected all zero",
                     instruction_flag, resp_addr, instruction, mem_read_flag, mem_read_address);
        end
    endtask

    task automatic test_basic();
        int cyc, mrf;
        logic [31:0] ra, ri;
        fetch(32'h0, 4, cyc, mrf, ra, ri);
        model_access(32'h0);
        checks++;
        if (cyc !== 5 || mrf !== 4 || ra !== 32'h0 || ri !== 32'h0000_0013) begin
            errors++;
            $display("FAIL first_miss: got cyc=%0d mrf=%0d addr=%h instr=%h, expected cyc=5 mrf=4 addr=0 instr=00000013",
                     cyc, mrf, ra, ri);
        end
        fetch(32'h0, 4, cyc, mrf, ra, ri);
        model_access(32'h0);
        checks++;
        if (cyc !== 1 || mrf !== 0 || ra !== 32'h0 || ri !== 32'h0000_0013) begin
            errors++;
            $display("FAIL repeat_hit: got cyc=%0d mrf=%0d addr=%h instr=%h, expected cyc=1 mrf=0 addr=0 instr=00000013",
                     cyc, mrf, ra, ri);
        end
`ifdef ICACHE_STAT_EN
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL stat_basic: got hits=%0d misses=%0d, expected 1 and 1", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_conflict();
        int cyc, mrf;
        logic [31:0] ra, ri;
        logic [31:0] seq [3];
        seq[0] = 32'h0000_0004;
        seq[1] = 32'h0000_0204;
        seq[2] = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            fetch(seq[i], 3, cyc, mrf, ra, ri);
            checks++;
            if (model_hit(seq[i]) || cyc !== 4 || mrf !== 3 || ra !== seq[i] || ri !== word_of(seq[i])) begin
                errors++;
                $display("FAIL conflict_miss[%0d]: got cyc=%0d mrf=%0d addr=%h instr=%h, expected miss cyc=4 mrf=3 addr=%h instr=%h",
                         i, cyc, mrf, ra, ri, seq[i], word_of(seq[i]));
            end
            model_access(seq[i]);
        end
    endtask

    task automatic test_redirect();
        int cyc, mrf;
        logic [31:0] ra, ri;
        bit got;
        mem_lat = 6;
        instruction_read_flag = 1'b1;
        instruction_read_address = 32'h0000_0100;
        repeat (2) @(posedge clk);
        #1;
        instruction_read_address = 32'h0000_0040;
        got = 1'b0;
        ra = 32'h0;
        ri = 32'h0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk);
            #1;
            if (instruction_flag) begin
                got = 1'b1;
                ra  = resp_addr;
                ri  = instruction;
            end
        end
        instruction_read_flag = 1'b0;
        @(posedge clk);
        #1;
        model_access(32'h0000_0100);
        model_access(32'h0000_0040);
        checks++;
        if (!got || ra !== 32'h0000_0040 || ri !== word_of(32'h0000_0040)) begin
            errors++;
            $display("FAIL redirect_resp: got seen=%0b addr=%h instr=%h, expected addr=00000040 instr=%h",
                     got, ra, ri, word_of(32'h40));
        end
        fetch(32'h0000_0100, 6, cyc, mrf, ra, ri);
        model_access(32'h0000_0100);
        checks++;
        if (cyc !== 1 || mrf !== 0 || ra !== 32'h100 || ri !== word_of(32'h100)) begin
            errors++;
            $display("FAIL redirect_fill_hit: got cyc=%0d mrf=%0d addr=%h instr=%h, expected hit addr=00000100 instr=%h",
                     cyc, mrf, ra, ri, word_of(32'h100));
        end
    endtask

    task automatic test_io();
        int cyc, mrf;
        logic [31:0] ra, ri;
        for (int i = 0; i < 2; i++) begin
            fetch(32'h0003_0000, 2, cyc, mrf, ra, ri);
            model_access(32'h0003_0000);
            checks++;
            if (cyc !== 3 || mrf !== 2 || ra !== 32'h0003_0000 || ri !== word_of(32'h0003_0000)) begin
                errors++;
                $display("FAIL io_uncached[%0d]: got cyc=%0d mrf=%0d addr=%h instr=%h, expected cyc=3 mrf=2 addr=00030000 instr=%h",
                         i, cyc, mrf, ra, ri, word_of(32'h30000));
            end
        end
    endtask

    task automatic test_reset_mid_miss();
        int cyc, mrf;
        logic [31:0] ra, ri;
        bit spurious;
        responder_en = 1'b0;
        mem_done = 1'b0;
        instruction_read_flag = 1'b1;
        instruction_read_address = 32'h0000_0080;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_read_flag !== 1'b1 || mem_read_address !== 32'h80) begin
            errors++;
            $display("FAIL rst_miss_pending: got mrf=%0b maddr=%h, expected 1 and 00000080", mem_read_flag, mem_read_address);
        end
        rst = 1'b1;
        instruction_read_flag = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (mem_read_flag !== 1'b0 || instruction_flag !== 1'b0) begin
            errors++;
            $display("FAIL rst_miss_drop: got mrf=%0b flag=%0b, expected 0 and 0", mem_read_flag, instruction_flag);
        end
        mem_done = 1'b1;
        mem_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_done = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (instruction_flag || mem_read_flag) spurious = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL rst_late_done: got activity after stale mem_done=1, expected 0");
        end
        responder_en = 1'b1;
        fetch(32'h0000_0080, 3, cyc, mrf, ra, ri);
        model_access(32'h0000_0080);
        checks++;
        if (cyc !== 4 || mrf !== 3 || ra !== 32'h80 || ri !== word_of(32'h80)) begin
            errors++;
            $display("FAIL rst_refetch_miss: got cyc=%0d mrf=%0d addr=%h instr=%h, expected cyc=4 mrf=3 addr=00000080 instr=%h",
                     cyc, mrf, ra, ri, word_of(32'h80));
        end
    endtask

    task automatic test_random();
        int cyc, mrf, lat, exp_cyc, exp_mrf;
        logic [31:0] a, ra, ri;
        for (int n = 0; n < 60; n++) begin
            a = {14'h0, 2'b00, 7'h0, 9'h0};
            a[8:2]   = 7'($urandom_range(0, 7));
            a[10:9]  = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a[17:16] = 2'b11;
            lat = $urandom_range(1, 5);
            exp_cyc = model_hit(a) ? 1 : lat + 1;
            exp_mrf = model_hit(a) ? 0 : lat;
            fetch(a, lat, cyc, mrf, ra, ri);
            model_access(a);
            checks++;
            if (cyc !== exp_cyc || mrf !== exp_mrf || ra !== a || ri !== word_of(a)) begin
                errors++;
                $display("FAIL random[%0d]: addr=%h got cyc=%0d mrf=%0d raddr=%h instr=%h, expected cyc=%0d mrf=%0d instr=%h",
                         n, a, cyc, mrf, ra, ri, exp_cyc, exp_mrf, word_of(a));
            end
        end
    endtask

    task automatic test_back_to_back();
        int hits;
        bit bad;
        logic [31:0] a;
        // Lines 0x0 and 0x40 are resident from earlier tests after refill here.
        int cyc, mrf;
        logic [31:0] ra, ri;
        fetch(32'h0, 2, cyc, mrf, ra, ri);
        model_access(32'h0);
        fetch(32'h40, 2, cyc, mrf, ra, ri);
        model_access(32'h40);
        hits = 0;
        bad  = 1'b0;
        instruction_read_flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = (i % 2 == 0) ? 32'h0 : 32'h40;
            instruction_read_address = a;
            model_access(a);
            @(posedge clk);
            #1;
            if (instruction_flag && resp_addr === a && instruction === word_of(a) && !mem_read_flag) hits++;
            else bad = 1'b1;
        end
        instruction_read_flag = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bad || hits != 6) begin
            errors++;
            $display("FAIL back_to_back: got %0d consecutive hit responses, expected 6", hits);
        end
`ifdef ICACHE_STAT_EN
        checks++;
        if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
            errors++;
            $display("FAIL stat_final: got hits=%0d misses=%0d, expected %0d and %0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        instruction_read_flag = 1'b0;
        instruction_read_address = 32'h0;
        model_reset();
        test_reset();
        test_basic();
        test_conflict();
        test_redirect();
        test_io();
        test_reset_mid_miss();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the IF stage (request side) and Mem_ctrl (instruction-fetch port).
- Hits answer in 1 cycle. Misses issue one 32-bit word fetch to Mem_ctrl, fill the line, then answer.
- The response interface is identical in shape to the Mem_ctrl instruction port, so IF consumes it unchanged.

Parameters:
- INDEX_BITS, 7, log2 of line count (128 one-word lines)
- ADDR_MSB, 17, highest address bit held in the tag; tag = addr[ADDR_MSB:INDEX_BITS+2]

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset (top drives rst_in | ~rdy_in); clears all valid bits and state
- instruction_read_flag  in  1  IF requests a fetch this cycle
- instruction_read_address  in  32  fetch address, word aligned
- instruction_flag  out  1  response valid (1-cycle pulse)
- _instruction_read_address  out  32  address the response belongs to
- instruction  out  32  fetched instruction word
- mem_read_flag  out  1  miss fetch request to Mem_ctrl, held until done
- mem_read_address  out  32  miss address
- mem_done  in  1  Mem_ctrl fetch complete (1-cycle pulse)
- mem_data  in  32  fetched word, valid with mem_done

Behaviour:
- Reset values: instruction_flag=0, _instruction_read_address=0, instruction=0, mem_read_flag=0, mem_read_address=0. All valid bits=0. State=IDLE.
- Storage: valid[2^INDEX_BITS], tag array, 32-bit data array. index = addr[INDEX_BITS+1:2]. addr[1:0] ignored.
- IDLE, request with a hit (valid & tag match): next edge drives instruction_flag=1, _instruction_read_address=addr, instruction=data. State stays IDLE. Back-to-back hits give one response per cycle.
- IDLE, request with a miss: next edge sets mem_read_flag=1 and mem_read_address=addr. State goes to MISS.
- IDLE, no request: instruction_flag=0.
- MISS: mem_read_flag and mem_read_address are held stable until mem_done.
  - On mem_done: write data/tag/valid for the line, drop mem_read_flag, go to RESP.
  - If IF's current request address equals mem_read_address, also drive the response on the same edge (miss latency = Mem_ctrl latency + 1).
- RESP: 1 cycle. instruction_flag=0. The newly filled line is visible to the lookup. Return to IDLE and service any pending request normally.
- Redirect mid-miss (IF address changes, e.g. branch mispredict):
  - The outstanding fetch is not aborted; Mem_ctrl cannot cancel.
  - The line is still filled on mem_done.
  - No response is issued for the stale address; the new address is serviced after RESP.
- IF drops instruction_read_flag mid-miss: same as redirect. Fill completes, no response.
- Fill to an index holding another tag overwrites it (no victim handling).
- Addresses with addr[17:16]==2'b11 (I/O) are never cached. They always take the miss path, and the returned word is forwarded without setting valid.
- rst mid-miss: state→IDLE, mem_read_flag=0 on the next edge, valid array cleared. A mem_done arriving later while IDLE is ignored.
- instruction_flag is never asserted in the same cycle as a mem_read_flag rising edge.

Optional Feature:
- ICACHE_STAT_EN defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - Each increments once per serviced request (hit on response, miss on MISS entry).
  - Both wrap at 2^32. Both cleared by rst.
- ICACHE_STAT_EN undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- After rst, request 0x00000000; Mem_ctrl returns 0x00000013 after 4 cycles → mem_read_flag held 4 cycles, then response flag=1, addr=0x0, instr=0x00000013. miss_count=1 if stat enabled.
- Repeat request 0x00000000 → response on the next cycle with 0x00000013, no mem_read_flag. hit_count=1.
- Fill 0x00000004, then request 0x00000204 (same index, INDEX_BITS=7) → miss, line replaced. Re-request 0x00000004 → miss again.
- Miss on 0x00000100; IF switches to 0x00000040 two cycles later → 0x100 filled, no response for 0x100. 0x40 then misses and responds with its own word. A later 0x100 request hits.
- Request 0x00030000 twice → both go to Mem_ctrl, valid bit never set.
- Assert rst during MISS, then deliver mem_done → no fill, no response. Re-request the same address → miss.
